// File: rtl/fpu_pkg.sv
`default_nettype none
//============================================================================
// Module  : fpu_pkg
// Shared opcodes, FSM states, flag indices and format helpers for fpu_seq.
// Revision: 1.0
//============================================================================
package fpu_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UNPACK = 3'd1,
        ST_EXEC   = 3'd2,
        ST_NORM   = 3'd3,
        ST_PACK   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam int FLAG_NX  = 0;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_OVF = 2;
    localparam int FLAG_INV = 3;

    // Helpers return 64-bit patterns; callers keep the low EXP_W+MAN_W+1 bits.
    function automatic int fmt_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic logic [63:0] fmt_inf(input int exp_w, input int man_w, input logic sign);
        logic [63:0] r;
        r = ((64'd1 << exp_w) - 64'd1) << man_w;
        r = r | (64'(sign) << (exp_w + man_w));
        return r;
    endfunction

    function automatic logic [63:0] fmt_nan(input int exp_w, input int man_w);
        return fmt_inf(exp_w, man_w, 1'b0) | (64'd1 << (man_w - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_norm.sv
`default_nettype none
//============================================================================
// Module  : fpu_norm
// Leading-zero count and normalising shifter; hidden bit lands at FW-2.
// Revision: 1.0
//============================================================================
module fpu_norm #(
    parameter int FW = 28,
    parameter int EW = 10
) (
    input  logic [FW-1:0] i_frame,
    input  logic [EW-1:0] i_exp,
    output logic [FW-1:0] o_frame,
    output logic [EW-1:0] o_exp
);
    localparam int LW = $clog2(FW);

    logic [LW-1:0] w_lz;
    logic          w_found;

    always_comb begin
        w_lz    = '0;
        w_found = 1'b0;
        for (int i = FW - 2; i >= 0; i--) begin
            if (!w_found) begin
                if (i_frame[i]) w_found = 1'b1;
                else            w_lz    = w_lz + LW'(1);
            end
        end
    end

    // Carry-out shifts right once, folding the dropped bits into sticky.
    always_comb begin
        if (i_frame[FW-1]) begin
            o_frame = {1'b0, i_frame[FW-1:2], |i_frame[1:0]};
            o_exp   = i_exp + EW'(1);
        end else begin
            o_frame = i_frame << w_lz;
            o_exp   = i_exp - EW'(w_lz);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpu_seq.sv
`default_nettype none
//============================================================================
// Module  : fpu_seq
// Multi-cycle add/sub/mul FPU (truncating) with valid/ready handshakes.
// Revision: 1.0
//============================================================================
module fpu_seq import fpu_pkg::*; #(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = EXP_W + MAN_W + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   opcode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] outp,
    output logic [3:0]   flags
);
    localparam int XW = MAN_W + 4;          // {hidden, mantissa, guard, round, sticky}
    localparam int FW = XW + 1;             // plus carry-out
    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * (MAN_W + 1);
    localparam int CW = $clog2(MAN_W + 2);

    localparam logic [63:0]          c_nan64    = fmt_nan(EXP_W, MAN_W);
    localparam logic [63:0]          c_inf64    = fmt_inf(EXP_W, MAN_W, 1'b0);
    localparam logic [W-1:0]         c_nan      = c_nan64[W-1:0];
    localparam logic [EW-1:0]        c_bias     = EW'(fmt_bias(EXP_W));
    localparam logic signed [EW-1:0] c_emax     = {2'b00, {EXP_W{1'b1}}};
    localparam logic signed [EW-1:0] c_ezero    = '0;
    localparam logic [PW-1:0]        c_plo_mask = (PW'(1) << (PW - XW)) - PW'(1);
    localparam logic [CW-1:0]        c_last     = CW'(MAN_W);

    state_t                r_state;
    logic [W-1:0]          r_a, r_b, r_outp, r_spec_res;
    logic [1:0]            r_op;
    logic [3:0]            r_flags;
    logic                  r_in_ready, r_out_valid;
    logic                  r_sign, r_effsub, r_special, r_invalid;
    logic signed [EW-1:0]  r_exp;
    logic [XW-1:0]         r_x, r_y;
    logic [FW-1:0]         r_frame;
    logic [PW-1:0]         r_acc;
    logic [MAN_W:0]        r_mcand;
    logic [CW-1:0]         r_cnt;

    logic                  w_sa, w_sb, w_za, w_zb, w_infa, w_infb, w_nana, w_nanb;
    logic [EXP_W-1:0]      w_ea, w_eb, w_xe, w_ye, w_d;
    logic [MAN_W:0]        w_siga, w_sigb, w_xs, w_ys;
    logic [W-2:0]          w_maga, w_magb;
    logic                  w_swap, w_effsub, w_xsign, w_yst;
    logic [MAN_W+2:0]      w_yfull, w_ysh;
    logic                  w_spec, w_spec_inv;
    logic [W-1:0]          w_spec_res;
    logic signed [EW-1:0]  w_mexp, w_nexp;
    logic [FW-1:0]         w_sum, w_pframe, w_nin, w_nframe;
    logic [MAN_W+1:0]      w_mstep;
    logic [MAN_W-1:0]      w_mant;
    logic                  w_nx;

    assign w_sa     = r_a[W-1];
    assign w_sb     = r_b[W-1];
    assign w_ea     = r_a[W-2:MAN_W];
    assign w_eb     = r_b[W-2:MAN_W];
    assign w_za     = (w_ea == '0);
    assign w_zb     = (w_eb == '0);
    assign w_infa   = (&w_ea) & ~(|r_a[MAN_W-1:0]);
    assign w_infb   = (&w_eb) & ~(|r_b[MAN_W-1:0]);
    assign w_nana   = (&w_ea) & (|r_a[MAN_W-1:0]);
    assign w_nanb   = (&w_eb) & (|r_b[MAN_W-1:0]);
    assign w_siga   = w_za ? '0 : {1'b1, r_a[MAN_W-1:0]};
    assign w_sigb   = w_zb ? '0 : {1'b1, r_b[MAN_W-1:0]};
    assign w_maga   = w_za ? '0 : r_a[W-2:0];
    assign w_magb   = w_zb ? '0 : r_b[W-2:0];
    assign w_effsub = w_sa ^ w_sb ^ r_op[0];
    assign w_swap   = (w_magb > w_maga);
    assign w_xsign  = w_swap ? (w_sb ^ r_op[0]) : w_sa;
    assign w_mexp   = {2'b00, w_ea} + {2'b00, w_eb} - c_bias;

    // Alignment: x is the larger magnitude, y is shifted right under it.
    always_comb begin
        w_xe    = w_swap ? w_eb : w_ea;
        w_ye    = w_swap ? w_ea : w_eb;
        w_xs    = w_swap ? w_sigb : w_siga;
        w_ys    = w_swap ? w_siga : w_sigb;
        w_d     = w_xe - w_ye;
        w_yfull = {w_ys, 2'b00};
        if (32'(w_d) >= MAN_W + 3) begin
            w_ysh = '0;
            w_yst = |w_ys;
        end else begin
            w_ysh = w_yfull >> w_d;
            w_yst = |(w_yfull & ~({(MAN_W+3){1'b1}} << w_d));
        end
    end

    always_comb begin
        w_spec     = 1'b0;
        w_spec_inv = 1'b0;
        w_spec_res = '0;
        if (r_op == OP_RSVD || w_nana || w_nanb) begin
            w_spec = 1'b1; w_spec_inv = 1'b1; w_spec_res = c_nan;
        end else if (r_op == OP_MUL) begin
            if ((w_infa && w_zb) || (w_za && w_infb)) begin
                w_spec = 1'b1; w_spec_inv = 1'b1; w_spec_res = c_nan;
            end else if (w_infa || w_infb) begin
                w_spec = 1'b1; w_spec_res = {w_sa ^ w_sb, c_inf64[W-2:0]};
            end else if (w_za || w_zb) begin
                w_spec = 1'b1; w_spec_res = {w_sa ^ w_sb, {(W-1){1'b0}}};
            end
        end else begin
            if (w_infa && w_infb && w_effsub) begin
                w_spec = 1'b1; w_spec_inv = 1'b1; w_spec_res = c_nan;
            end else if (w_infa) begin
                w_spec = 1'b1; w_spec_res = {w_sa, c_inf64[W-2:0]};
            end else if (w_infb) begin
                w_spec = 1'b1; w_spec_res = {w_sb ^ r_op[0], c_inf64[W-2:0]};
            end
        end
    end

    assign w_sum    = r_effsub ? ({1'b0, r_x} - {1'b0, r_y}) : ({1'b0, r_x} + {1'b0, r_y});
    assign w_mstep  = {1'b0, r_acc[PW-1:MAN_W+1]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    // Product carry bit lines up with the adder's carry-out position.
    assign w_pframe = {r_acc[PW-1:PW-XW], |(r_acc & c_plo_mask)};
    assign w_nin    = (r_op == OP_MUL) ? w_pframe : r_frame;
    assign w_mant   = r_frame[XW-2:3];
    assign w_nx     = |r_frame[2:0];

    fpu_norm #(.FW(FW), .EW(EW)) u_norm (
        .i_frame (w_nin),
        .i_exp   (r_exp),
        .o_frame (w_nframe),
        .o_exp   (w_nexp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_outp      <= '0;
            r_flags     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (in_valid && r_in_ready) begin
                    r_a        <= a;
                    r_b        <= b;
                    r_op       <= opcode;
                    r_flags    <= '0;
                    r_in_ready <= 1'b0;
                    r_state    <= ST_UNPACK;
                end
                ST_UNPACK: begin
                    r_special  <= w_spec;
                    r_invalid  <= w_spec_inv;
                    r_spec_res <= w_spec_res;
                    r_effsub   <= w_effsub;
                    r_cnt      <= '0;
                    r_x        <= {w_xs, 3'b000};
                    r_y        <= {w_ysh, w_yst};
                    r_acc      <= {{(MAN_W+1){1'b0}}, w_sigb};
                    r_mcand    <= w_siga;
                    if (r_op == OP_MUL) begin
                        r_exp  <= w_mexp;
                        r_sign <= w_sa ^ w_sb;
                    end else begin
                        r_exp  <= {2'b00, w_xe};
                        r_sign <= w_xsign;
                    end
                    r_state <= w_spec ? ST_PACK : ST_EXEC;
                end
                ST_EXEC: begin
                    if (r_op == OP_MUL) begin
                        r_acc <= {w_mstep, r_acc[MAN_W:1]};
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == c_last) r_state <= ST_NORM;
                    end else begin
                        r_frame <= w_sum;
                        // Exact cancellation is +0; like-signed zeros keep their sign.
                        if (w_sum == '0) begin
                            r_special  <= 1'b1;
                            r_spec_res <= {r_sign & ~r_effsub, {(W-1){1'b0}}};
                        end
                        r_state <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    r_frame <= w_nframe;
                    r_exp   <= w_nexp;
                    r_state <= ST_PACK;
                end
                ST_PACK: begin
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                    r_flags     <= '0;
                    if (r_special) begin
                        r_outp            <= r_spec_res;
                        r_flags[FLAG_INV] <= r_invalid;
                    end else if (r_exp >= c_emax) begin
                        r_outp            <= {r_sign, c_inf64[W-2:0]};
                        r_flags[FLAG_OVF] <= 1'b1;
                        r_flags[FLAG_NX]  <= 1'b1;
                    end else if (r_exp <= c_ezero) begin
                        r_outp            <= {r_sign, {(W-1){1'b0}}};
                        r_flags[FLAG_UNF] <= 1'b1;
                        r_flags[FLAG_NX]  <= 1'b1;
                    end else begin
                        r_outp           <= {r_sign, r_exp[EXP_W-1:0], w_mant};
                        r_flags[FLAG_NX] <= w_nx;
                    end
                end
                ST_DONE: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_in_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign outp      = r_outp;
    assign flags     = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_fpu_seq.sv
`default_nettype none
//============================================================================
// Module  : tb_fpu_seq
// Directed bench for fpu_seq at single-precision and half-precision formats.
// Revision: 1.0
//============================================================================
module tb_fpu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, outp;
    logic [1:0]  opcode;
    logic [3:0]  flags;

    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0] h_a, h_b, h_outp;
    logic [1:0]  h_opcode;
    logic [3:0]  h_flags;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    fpu_seq u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .opcode(opcode), .out_valid(out_valid),
        .out_ready(out_ready), .outp(outp), .flags(flags)
    );

    fpu_seq #(.EXP_W(5), .MAN_W(10)) u_half (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b), .opcode(h_opcode), .out_valid(h_out_valid),
        .out_ready(h_out_ready), .outp(h_outp), .flags(h_flags)
    );

    // Latency counts clock edges from the accepting edge to out_valid; -1 on timeout.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic [1:0] top,
                          output logic [31:0] res, output logic [3:0] fl, output int lat);
        @(negedge clk);
        a = ta; b = tb_; opcode = top; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        res = outp; fl = flags;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_half(input logic [15:0] ta, input logic [15:0] tb_, input logic [1:0] top,
                            output logic [15:0] res, output logic [3:0] fl, output int lat);
        @(negedge clk);
        h_a = ta; h_b = tb_; h_opcode = top; h_in_valid = 1'b1;
        @(posedge clk); #1;
        h_in_valid = 1'b0;
        lat = 1;
        while (!h_out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!h_out_valid) lat = -1;
        res = h_outp; fl = h_flags;
        h_out_ready = 1'b1;
        @(posedge clk); #1;
        h_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        checks++; if (outp !== 32'h0) $display("FAIL reset_outp got %h want 00000000", outp); else passed++;
        checks++; if (flags !== 4'h0) $display("FAIL reset_flags got %b want 0000", flags); else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        logic [31:0] r; logic [3:0] f; int l;
        run_op(32'h3FC00000, 32'h40100000, 2'b00, r, f, l);
        checks++; if (r !== 32'h40700000) $display("FAIL add_result got %h want 40700000", r); else passed++;
        checks++; if (f !== 4'b0000) $display("FAIL add_flags got %b want 0000", f); else passed++;
        checks++; if (l !== 5) $display("FAIL add_latency got %0d want 5", l); else passed++;
    endtask

    task automatic test_sub_zero();
        logic [31:0] r; logic [3:0] f; int l;
        run_op(32'h3F800000, 32'h3F800000, 2'b01, r, f, l);
        checks++; if (r !== 32'h00000000) $display("FAIL sub_cancel got %h want 00000000", r); else passed++;
        checks++; if (f !== 4'b0000) $display("FAIL sub_cancel_flags got %b want 0000", f); else passed++;
        run_op(32'h00000001, 32'h3F800000, 2'b00, r, f, l);
        checks++; if (r !== 32'h3F800000) $display("FAIL add_denorm got %h want 3F800000", r); else passed++;
    endtask

    task automatic test_mul();
        logic [31:0] r; logic [3:0] f; int l;
        run_op(32'h40000000, 32'h40400000, 2'b10, r, f, l);
        checks++; if (r !== 32'h40C00000) $display("FAIL mul_2x3 got %h want 40C00000", r); else passed++;
        checks++; if (l !== 28) $display("FAIL mul_latency got %0d want 28", l); else passed++;
        run_op(32'h3F800001, 32'h3F800001, 2'b10, r, f, l);
        checks++; if (r !== 32'h3F800002) $display("FAIL mul_trunc got %h want 3F800002", r); else passed++;
        checks++; if (f !== 4'b0001) $display("FAIL mul_trunc_flags got %b want 0001", f); else passed++;
    endtask

    task automatic test_special();
        logic [31:0] r; logic [3:0] f; int l;
        run_op(32'h7F000000, 32'h7F000000, 2'b10, r, f, l);
        checks++; if (r !== 32'h7F800000) $display("FAIL mul_overflow got %h want 7F800000", r); else passed++;
        checks++; if (f[2] !== 1'b1) $display("FAIL mul_overflow_flag got %b want 1", f[2]); else passed++;
        run_op(32'h00800000, 32'h00800000, 2'b10, r, f, l);
        checks++; if (r !== 32'h00000000) $display("FAIL mul_underflow got %h want 00000000", r); else passed++;
        checks++; if (f[1] !== 1'b1) $display("FAIL mul_underflow_flag got %b want 1", f[1]); else passed++;
        run_op(32'h7F800000, 32'hFF800000, 2'b00, r, f, l);
        checks++; if (r !== 32'h7FC00000) $display("FAIL inf_minus_inf got %h want 7FC00000", r); else passed++;
        checks++; if (f !== 4'b1000) $display("FAIL inf_minus_inf_flags got %b want 1000", f); else passed++;
    endtask

    task automatic test_backpressure();
        logic [31:0] snap_o; logic [3:0] snap_f; logic ok; int n;
        @(negedge clk);
        a = 32'h3FC00000; b = 32'h40100000; opcode = 2'b00; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        snap_o = outp; snap_f = flags; ok = out_valid;
        a = 32'h40100000; b = 32'h40100000; in_valid = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (outp !== snap_o || flags !== snap_f || out_valid !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
        end
        checks++; if (ok !== 1'b1) $display("FAIL bp_hold got %b want 1", ok); else passed++;
        checks++; if (snap_o !== 32'h40700000) $display("FAIL bp_result got %h want 40700000", snap_o); else passed++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) $display("FAIL bp_idle_ready got %b want 1", in_ready); else passed++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        checks++; if (outp !== 32'h40900000) $display("FAIL bp_next_result got %h want 40900000", outp); else passed++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_mul();
        logic [31:0] r; logic [3:0] f; int l; logic seen;
        @(negedge clk);
        a = 32'h40000000; b = 32'h40400000; opcode = 2'b10; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL rst_mid_out_valid got %b want 0", out_valid); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL rst_mid_in_ready got %b want 1", in_ready); else passed++;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        checks++; if (seen !== 1'b0) $display("FAIL rst_mid_no_result got %b want 0", seen); else passed++;
        run_op(32'h3FC00000, 32'h40100000, 2'b00, r, f, l);
        checks++; if (r !== 32'h40700000) $display("FAIL rst_mid_add got %h want 40700000", r); else passed++;
    endtask

    task automatic test_half();
        logic [15:0] r; logic [3:0] f; int l;
        run_half(16'h3C00, 16'h3C00, 2'b00, r, f, l);
        checks++; if (r !== 16'h4000) $display("FAIL half_add got %h want 4000", r); else passed++;
        run_half(16'h4000, 16'h4200, 2'b10, r, f, l);
        checks++; if (r !== 16'h4600) $display("FAIL half_mul got %h want 4600", r); else passed++;
        checks++; if (l !== 15) $display("FAIL half_mul_latency got %0d want 15", l); else passed++;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; opcode = '0;
        h_in_valid = 1'b0; h_out_ready = 1'b0; h_a = '0; h_b = '0; h_opcode = '0;
        test_reset();
        test_add();
        test_sub_zero();
        test_mul();
        test_special();
        test_backpressure();
        test_reset_mid_mul();
        test_half();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
